// File: rtl/arbiter_if.sv
// Client-side port bundle for the feature-map arbiter: one write port and one read port.
// Coordinates are (x,y) pairs and data words are channel arrays (channel 0 in the low bits).
interface arbiter_if #(
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8
);
  typedef struct packed {
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
  } vec2_t;

  // write port
  logic                                     write_req;
  logic                                     write_ready;
  vec2_t                                    coord_wtr;
  logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] data_in;

  // read port
  logic                                     read_req;
  logic                                     read_ready;
  vec2_t                                    coord_rd;
  logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] data_out;

  modport arbiter (
    input  write_req, coord_wtr, data_in, read_req, coord_rd,
    output write_ready, read_ready, data_out
  );

  modport client (
    output write_req, coord_wtr, data_in, read_req, coord_rd,
    input  write_ready, read_ready, data_out
  );
endinterface

// File: rtl/fm_arbiter.sv
// Shares one single-port feature-map RAM between the conv and pool clients.
// One RAM op per cycle, writes before reads, per-class round robin, plus a whole-map clear sweep.
module fm_arbiter #(
  parameter int   COORD_BITS       = 8,
  parameter int   CHANNELS         = 4,
  parameter int   BITS_PER_CHANNEL = 8,
  parameter int   FM_WIDTH         = 32,
  parameter int   FM_HEIGHT        = 32,
  localparam int  ADDR_BITS        = $clog2(FM_WIDTH*FM_HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  arbiter_if.arbiter                           conv,
  arbiter_if.arbiter                           pool,
  input  logic                                 clear_start,
  output logic                                 busy,
  output logic                                 clear_done,
  output logic                                 err_oob,
  output logic [ADDR_BITS-1:0]                 mem_addr,
  output logic                                 mem_we,
  output logic                                 mem_re,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] mem_wdata,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] mem_rdata
);

  localparam int DW   = CHANNELS*BITS_PER_CHANNEL;
  localparam int NPIX = FM_WIDTH*FM_HEIGHT;
  localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(NPIX-1);
  // one extra bit so a map dimension equal to 2**COORD_BITS never aliases to zero
  localparam logic [COORD_BITS:0]   X_LIM     = (COORD_BITS+1)'(FM_WIDTH);
  localparam logic [COORD_BITS:0]   Y_LIM     = (COORD_BITS+1)'(FM_HEIGHT);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  function automatic logic is_oob(input logic [COORD_BITS-1:0] x,
                                  input logic [COORD_BITS-1:0] y);
    return ({1'b0, x} >= X_LIM) || ({1'b0, y} >= Y_LIM);
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_of(input logic [COORD_BITS-1:0] x,
                                                   input logic [COORD_BITS-1:0] y);
    return ADDR_BITS'(y) * ADDR_BITS'(FM_WIDTH) + ADDR_BITS'(x);
  endfunction

  state_t                        state_q, state_d;
  logic [ADDR_BITS-1:0]          clr_cnt_q;
  logic                          wr_ptr_q, rd_ptr_q;   // 0 favours conv, 1 favours pool
  logic [1:0]                    rd_ready_q;           // doubles as the outstanding-read flag
  logic                          rd_zero_q;
  logic [1:0][DW-1:0]            held_q;

  logic [1:0]                    wr_req, rd_elig, wr_oob, rd_oob;
  logic [1:0][ADDR_BITS-1:0]     wr_addr, rd_addr;
  logic [1:0][DW-1:0]            wr_data;
  logic [1:0]                    gnt_w, gnt_r;
  logic [DW-1:0]                 rd_word;

  // index 0 = conv, index 1 = pool
  always_comb begin
    wr_req     = {pool.write_req, conv.write_req};
    rd_elig    = {pool.read_req, conv.read_req} & ~rd_ready_q;
    wr_oob[0]  = is_oob(conv.coord_wtr.x, conv.coord_wtr.y);
    wr_oob[1]  = is_oob(pool.coord_wtr.x, pool.coord_wtr.y);
    rd_oob[0]  = is_oob(conv.coord_rd.x,  conv.coord_rd.y);
    rd_oob[1]  = is_oob(pool.coord_rd.x,  pool.coord_rd.y);
    wr_addr[0] = addr_of(conv.coord_wtr.x, conv.coord_wtr.y);
    wr_addr[1] = addr_of(pool.coord_wtr.x, pool.coord_wtr.y);
    rd_addr[0] = addr_of(conv.coord_rd.x,  conv.coord_rd.y);
    rd_addr[1] = addr_of(pool.coord_rd.x,  pool.coord_rd.y);
    wr_data[0] = conv.data_in;
    wr_data[1] = pool.data_in;
  end

  // Single winner per cycle; an out-of-range winner still takes the grant but touches no RAM.
  always_comb begin
    gnt_w = 2'b00;
    gnt_r = 2'b00;
    if (rst_n && state_q == ST_IDLE) begin
      if (|wr_req)
        gnt_w = (wr_req == 2'b11) ? (wr_ptr_q ? 2'b10 : 2'b01) : wr_req;
      else if (|rd_elig)
        gnt_r = (rd_elig == 2'b11) ? (rd_ptr_q ? 2'b10 : 2'b01) : rd_elig;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          for (int c = 0; c < 2; c++) begin
            if (gnt_w[c] && !wr_oob[c]) begin
              mem_we    = 1'b1;
              mem_addr  = wr_addr[c];
              mem_wdata = wr_data[c];
            end
            if (gnt_r[c] && !rd_oob[c]) begin
              mem_re   = 1'b1;
              mem_addr = rd_addr[c];
            end
          end
          if (clear_start) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          busy     = 1'b1;
          mem_we   = 1'b1;
          mem_addr = clr_cnt_q;
          if (clr_cnt_q == LAST_ADDR) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_ready_q <= 2'b00;
      rd_zero_q  <= 1'b0;
      held_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
      clear_done <= (state_q == ST_CLEAR) && (state_d == ST_IDLE);
      if (|gnt_w) wr_ptr_q <= gnt_w[0];
      if (|gnt_r) rd_ptr_q <= gnt_r[0];
      rd_ready_q <= gnt_r;
      rd_zero_q  <= |(gnt_r & rd_oob);
      if (|((gnt_w & wr_oob) | (gnt_r & rd_oob))) err_oob <= 1'b1;
      for (int c = 0; c < 2; c++)
        if (rd_ready_q[c]) held_q[c] <= rd_word;
    end
  end

  // Read data is shown straight from the RAM during the pulse and held from a register after it.
  assign rd_word = rd_zero_q ? '0 : mem_rdata;

  assign conv.write_ready = gnt_w[0];
  assign pool.write_ready = gnt_w[1];
  assign conv.read_ready  = rd_ready_q[0];
  assign pool.read_ready  = rd_ready_q[1];
  assign conv.data_out    = rd_ready_q[0] ? rd_word : held_q[0];
  assign pool.data_out    = rd_ready_q[1] ? rd_word : held_q[1];

endmodule
